acc_adder_unit: RTL and testbench
=================================

ACC_ADDER_UNIT -- requirements
Module: acc_adder_unit

Interface
REQ-001 Parameter WIDTH, default 8: operand, result and accumulator width in bits; legal range 2..32.
REQ-002 Parameter CNT_WIDTH, default 4: width of the accumulate-operation counter; legal range 1..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  global enable; low = whole pipeline holds state (stall).
REQ-006 in_valid  input  1  operands and mode valid this cycle.
REQ-007 op_a  input  WIDTH  unsigned operand A.
REQ-008 op_b  input  WIDTH  unsigned operand B.
REQ-009 mode  input  2  operation: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
REQ-010 out_valid  output  1  result, flag and acc_cnt valid this cycle.
REQ-011 result  output  WIDTH  registered operation result.
REQ-012 flag  output  1  carry (ADD/ACC) or borrow (SUB) of the reported operation.
REQ-013 acc_cnt  output  CNT_WIDTH  number of ACC operations since the last CLR or reset.

Function
REQ-014 Two-stage pipeline: stage 1 registers in_valid, op_a, op_b, mode; stage 2 computes and registers result, flag, out_valid.
REQ-015 Latency is exactly 2 enabled cycles from in_valid sampled high to out_valid high; throughput one operation per enabled cycle.
REQ-016 ADD: result = (op_a + op_b) mod 2^WIDTH, flag = carry out of bit WIDTH-1.
REQ-017 SUB: result = (op_a - op_b) mod 2^WIDTH, flag = 1 when op_b > op_a.
REQ-018 ACC: internal accumulator acc <= acc + op_a (op_b ignored); result = new acc value; flag = carry; acc_cnt increments.
REQ-019 CLR: acc <= 0, acc_cnt <= 0, result = 0, flag = 0; out_valid asserted as for other modes.
REQ-020 Back-to-back ACC operations on consecutive cycles each see the accumulator value produced by the preceding ACC; no bubble.
REQ-021 ADD and SUB do not modify acc or acc_cnt.
REQ-022 acc_cnt saturates at 2^CNT_WIDTH-1; further ACC operations leave it unchanged.
REQ-023 Stage with valid low: result, flag, acc and acc_cnt hold their values; out_valid = 0.
REQ-024 ena low: no register in either stage changes; outputs hold; in_valid is ignored that cycle.
REQ-025 ena returning high resumes from the held state with no loss or duplication of in-flight operations.

Reset
REQ-026 On rst_n low: out_valid = 0, result = 0, flag = 0, acc_cnt = 0, accumulator = 0, all stage-1 registers = 0, immediately and independent of clk.
REQ-027 Reset asserted mid-operation discards all in-flight operations; first out_valid after release is 2 enabled cycles after the first sampled in_valid.
REQ-028 Reset deassertion is synchronised to clk by the integrating level; the block assumes no release within setup/hold of clk.

Configuration
REQ-029 Macro ACC_ADDER_UNIT_SAT_EN defined: ADD and ACC overflow clamp result (and acc) to 2^WIDTH-1; SUB underflow clamps result to 0; flag still set as in REQ-016..018.
REQ-030 Macro ACC_ADDER_UNIT_SAT_EN undefined: modulo wrap-around as in REQ-016..018; no saturation logic present.

Structure
REQ-031 Shared package acc_adder_pkg holds the mode typedef (2-bit enum ADD/SUB/ACC/CLR) and mode encoding constants.
REQ-032 Arithmetic (add/sub with carry/borrow and optional saturation) is one combinational sub-module acc_adder_core, instantiated once in stage 2.

Verification
REQ-033 WIDTH=8: ADD 0xF0+0x20 -> 2 cycles later out_valid=1, result=0x10, flag=1 (SAT_EN: result=0xFF, flag=1).
REQ-034 SUB 0x05-0x07 -> result=0xFE, flag=1 (SAT_EN: result=0x00); SUB 0x07-0x05 -> result=0x02, flag=0.
REQ-035 CLR then ACC 0x10, 0x20, 0x30 on consecutive cycles -> results 0x10, 0x30, 0x60 on consecutive cycles, acc_cnt 1,2,3, flag=0.
REQ-036 ACC stream with ena low for 3 cycles mid-stream -> outputs frozen during stall, sequence resumes unchanged, no duplicate out_valid.
REQ-037 CNT_WIDTH=4: 17 consecutive ACC ops -> acc_cnt reaches 15 and stays 15; following CLR -> acc_cnt=0, result=0.
REQ-038 rst_n pulsed low while two ops are in flight -> all outputs 0 immediately, no out_valid for discarded ops, acc=0 on next ACC.

Source files
------------

// File: rtl/acc_adder_pkg.sv
// Shared definitions for the accumulate/adder unit: mode encodings and the
// mode enum used on the operand interface and inside the pipeline.
package acc_adder_pkg;

    localparam logic [1:0] ENC_ADD = 2'b00;
    localparam logic [1:0] ENC_SUB = 2'b01;
    localparam logic [1:0] ENC_ACC = 2'b10;
    localparam logic [1:0] ENC_CLR = 2'b11;

    typedef enum logic [1:0] {
        MODE_ADD = ENC_ADD,
        MODE_SUB = ENC_SUB,
        MODE_ACC = ENC_ACC,
        MODE_CLR = ENC_CLR
    } mode_e;

endpackage

// File: rtl/acc_adder_unit_if.sv
// Operand/result bundle for acc_adder_unit. The master drives operands and
// consumes results; the slave is the arithmetic unit itself.
interface acc_adder_unit_if
    import acc_adder_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4
);
    logic                 in_valid;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    mode_e                mode;
    logic                 out_valid;
    logic [WIDTH-1:0]     result;
    logic                 flag;
    logic [CNT_WIDTH-1:0] acc_cnt;

    modport master (
        output in_valid, op_a, op_b, mode,
        input  out_valid, result, flag, acc_cnt
    );

    modport slave (
        input  in_valid, op_a, op_b, mode,
        output out_valid, result, flag, acc_cnt
    );
endinterface

// File: rtl/acc_adder_core.sv
// Combinational add/subtract with carry/borrow out.
// Optional saturation is enabled by defining ACC_ADDER_UNIT_SAT_EN:
// overflow clamps to all-ones, underflow clamps to zero; flag is unaffected.
module acc_adder_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] y,
    output logic             flag
);
    logic [WIDTH:0] ext;

    // One extra bit captures carry (add) or borrow (sub, set when b > a).
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        ext  = '0;
        y    = '0;
        flag = 1'b0;
        if (sub) begin
            ext = {1'b0, a} - {1'b0, b};
        end else begin
            ext = {1'b0, a} + {1'b0, b};
        end
        flag = ext[WIDTH];
`ifdef ACC_ADDER_UNIT_SAT_EN
        if (flag) begin
            y = sub ? '0 : '1;
        end else begin
            y = ext[WIDTH-1:0];
        end
`else
        y = ext[WIDTH-1:0];
`endif
    end
endmodule

// File: rtl/acc_adder_unit.sv
// Two-stage add/sub/accumulate unit. Stage 1 registers the request, stage 2
// computes through acc_adder_core and registers result, flag and the
// accumulator state. ena low freezes both stages.
// Optional build macro: ACC_ADDER_UNIT_SAT_EN (saturating arithmetic).
module acc_adder_unit
    import acc_adder_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    acc_adder_unit_if.slave bus
);
    // Stage 1 request registers
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    mode_e            s1_mode;

    // Stage 2 output and accumulator state
    logic                 out_valid_q;
    logic [WIDTH-1:0]     result_q;
    logic                 flag_q;
    logic [WIDTH-1:0]     acc_q;
    logic [CNT_WIDTH-1:0] acc_cnt_q;

    // Core operand selection
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic             core_sub;
    logic [WIDTH-1:0] core_y;
    logic             core_flag;

    // Capture the request; ena low holds everything, ignoring in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mode  <= MODE_ADD;
        end else if (ena) begin
            // NOTE: non-blocking so every register samples pre-edge values.
            s1_valid <= bus.in_valid;
            s1_a     <= bus.op_a;
            s1_b     <= bus.op_b;
            s1_mode  <= bus.mode;
        end
    end

    // ACC adds op_a to the live accumulator, so back-to-back ACCs chain
    // through acc_q without a bubble; ADD/SUB use both operands directly.
    always_comb begin
        core_a   = s1_a;
        core_b   = s1_b;
        core_sub = (s1_mode == MODE_SUB);
        if (s1_mode == MODE_ACC) begin
            core_a = acc_q;
            core_b = s1_a;
        end
    end

    acc_adder_core #(.WIDTH(WIDTH)) u_core (
        .a    (core_a),
        .b    (core_b),
        .sub  (core_sub),
        .y    (core_y),
        .flag (core_flag)
    );

    // Register the result of a valid request and update accumulator state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_q      <= 1'b0;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
        end else if (ena) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                unique case (s1_mode)
                    MODE_ADD, MODE_SUB: begin
                        result_q <= core_y;
                        flag_q   <= core_flag;
                    end
                    MODE_ACC: begin
                        result_q <= core_y;
                        flag_q   <= core_flag;
                        acc_q    <= core_y;
                        if (acc_cnt_q != '1) begin
                            acc_cnt_q <= acc_cnt_q + 1'b1;
                        end
                    end
                    MODE_CLR: begin
                        result_q  <= '0;
                        flag_q    <= 1'b0;
                        acc_q     <= '0;
                        acc_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flag      = flag_q;
    assign bus.acc_cnt   = acc_cnt_q;
endmodule

// File: tb/tb_acc_adder_unit.sv
// Directed bench for acc_adder_unit (WIDTH=8, CNT_WIDTH=4). Expected values
// follow ACC_ADDER_UNIT_SAT_EN when the bench is built with it defined.
module tb_acc_adder_unit;
    import acc_adder_pkg::*;

    localparam int WIDTH     = 8;
    localparam int CNT_WIDTH = 4;
    localparam int NVEC      = 14;

    typedef struct {
        mode_e          mode;
        logic [7:0]     a;
        logic [7:0]     b;
        logic [7:0]     res;
        logic           flag;
        logic [3:0]     cnt;
    } vec_t;

    logic clk;
    logic rst_n;
    logic ena;
    int   checks;
    int   errors;
    vec_t tbl [NVEC];

    acc_adder_unit_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    acc_adder_unit #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input mode_e m, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = v;
        bus.mode     = m;
        bus.op_a     = a;
        bus.op_b     = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic v, input logic [7:0] r,
                             input logic f, input logic [3:0] c);
        check({name, ".out_valid"}, 32'(bus.out_valid), 32'(v));
        check({name, ".result"},    32'(bus.result),    32'(r));
        check({name, ".flag"},      32'(bus.flag),      32'(f));
        check({name, ".acc_cnt"},   32'(bus.acc_cnt),   32'(c));
    endtask

    initial begin
        checks = 0;
        errors = 0;

`ifdef ACC_ADDER_UNIT_SAT_EN
        tbl[0]  = '{MODE_CLR, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0};
        tbl[1]  = '{MODE_ADD, 8'hF0, 8'h20, 8'hFF, 1'b1, 4'd0};
        tbl[2]  = '{MODE_SUB, 8'h05, 8'h07, 8'h00, 1'b1, 4'd0};
        tbl[3]  = '{MODE_SUB, 8'h07, 8'h05, 8'h02, 1'b0, 4'd0};
        tbl[4]  = '{MODE_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 4'd0};
        tbl[5]  = '{MODE_ACC, 8'h10, 8'hFF, 8'h10, 1'b0, 4'd1};
        tbl[6]  = '{MODE_ACC, 8'h20, 8'h00, 8'h30, 1'b0, 4'd2};
        tbl[7]  = '{MODE_ACC, 8'h30, 8'h00, 8'h60, 1'b0, 4'd3};
        tbl[8]  = '{MODE_ADD, 8'hFF, 8'h01, 8'hFF, 1'b1, 4'd3};
        tbl[9]  = '{MODE_ACC, 8'hC0, 8'h00, 8'hFF, 1'b1, 4'd4};
        tbl[10] = '{MODE_ACC, 8'h01, 8'h00, 8'hFF, 1'b1, 4'd5};
`else
        tbl[0]  = '{MODE_CLR, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0};
        tbl[1]  = '{MODE_ADD, 8'hF0, 8'h20, 8'h10, 1'b1, 4'd0};
        tbl[2]  = '{MODE_SUB, 8'h05, 8'h07, 8'hFE, 1'b1, 4'd0};
        tbl[3]  = '{MODE_SUB, 8'h07, 8'h05, 8'h02, 1'b0, 4'd0};
        tbl[4]  = '{MODE_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 4'd0};
        tbl[5]  = '{MODE_ACC, 8'h10, 8'hFF, 8'h10, 1'b0, 4'd1};
        tbl[6]  = '{MODE_ACC, 8'h20, 8'h00, 8'h30, 1'b0, 4'd2};
        tbl[7]  = '{MODE_ACC, 8'h30, 8'h00, 8'h60, 1'b0, 4'd3};
        tbl[8]  = '{MODE_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 4'd3};
        tbl[9]  = '{MODE_ACC, 8'hC0, 8'h00, 8'h20, 1'b1, 4'd4};
        tbl[10] = '{MODE_ACC, 8'h01, 8'h00, 8'h21, 1'b0, 4'd5};
`endif
        tbl[11] = '{MODE_SUB, 8'h00, 8'h00, 8'h00, 1'b0, 4'd5};
        tbl[12] = '{MODE_CLR, 8'hAA, 8'h55, 8'h00, 1'b0, 4'd0};
        tbl[13] = '{MODE_ACC, 8'h05, 8'h00, 8'h05, 1'b0, 4'd1};

        // Reset state, checked before any clock edge.
        rst_n = 1'b0;
        ena   = 1'b1;
        drive(1'b0, MODE_ADD, 8'h00, 8'h00);
        #1;
        check_out("reset", 1'b0, 8'h00, 1'b0, 4'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        // Back-to-back table stream: vector i appears two cycles after issue.
        for (int i = 0; i <= NVEC; i++) begin
            if (i < NVEC) drive(1'b1, tbl[i].mode, tbl[i].a, tbl[i].b);
            else          drive(1'b0, MODE_ADD, 8'h00, 8'h00);
            step();
            if (i >= 1) begin
                check_out($sformatf("vec%0d", i - 1), 1'b1, tbl[i-1].res,
                          tbl[i-1].flag, tbl[i-1].cnt);
            end
        end
        drive(1'b0, MODE_ADD, 8'h00, 8'h00);
        step();
        check_out("idle_hold", 1'b0, 8'h05, 1'b0, 4'd1);

        // Stall mid ACC stream: outputs freeze, in_valid ignored while ena low.
        drive(1'b1, MODE_CLR, 8'h00, 8'h00); step();
        drive(1'b1, MODE_ACC, 8'h01, 8'h00); step();
        drive(1'b1, MODE_ACC, 8'h02, 8'h00); step();
        check_out("stall_pre", 1'b1, 8'h01, 1'b0, 4'd1);
        ena = 1'b0;
        drive(1'b1, MODE_ACC, 8'h40, 8'h00);
        for (int k = 0; k < 3; k++) begin
            step();
            check_out($sformatf("stall%0d", k), 1'b1, 8'h01, 1'b0, 4'd1);
        end
        ena = 1'b1;
        drive(1'b1, MODE_ACC, 8'h03, 8'h00); step();
        check_out("resume0", 1'b1, 8'h03, 1'b0, 4'd2);
        drive(1'b0, MODE_ADD, 8'h00, 8'h00); step();
        check_out("resume1", 1'b1, 8'h06, 1'b0, 4'd3);
        step();
        check_out("resume_end", 1'b0, 8'h06, 1'b0, 4'd3);

        // Counter saturation: 17 ACCs of 1, then CLR.
        drive(1'b1, MODE_CLR, 8'h00, 8'h00); step();
        for (int i = 0; i <= 17; i++) begin
            if (i < 17) drive(1'b1, MODE_ACC, 8'h01, 8'h00);
            else        drive(1'b0, MODE_ADD, 8'h00, 8'h00);
            step();
            check_out($sformatf("sat%0d", i), 1'b1, 8'(i), 1'b0, 4'((i > 15) ? 15 : i));
        end
        drive(1'b1, MODE_CLR, 8'h00, 8'h00); step();
        check_out("sat_gap", 1'b0, 8'd17, 1'b0, 4'd15);
        drive(1'b0, MODE_ADD, 8'h00, 8'h00); step();
        check_out("sat_clr", 1'b1, 8'h00, 1'b0, 4'd0);

        // Reset with two operations in flight.
        drive(1'b1, MODE_ACC, 8'h33, 8'h00); step();
        drive(1'b1, MODE_ACC, 8'h44, 8'h00); step();
        drive(1'b0, MODE_ADD, 8'h00, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        check_out("rst_async", 1'b0, 8'h00, 1'b0, 4'd0);
        step();
        check_out("rst_held", 1'b0, 8'h00, 1'b0, 4'd0);
        #2 rst_n = 1'b1;
        step();
        check_out("rst_rel0", 1'b0, 8'h00, 1'b0, 4'd0);
        step();
        check_out("rst_rel1", 1'b0, 8'h00, 1'b0, 4'd0);
        drive(1'b1, MODE_ACC, 8'h07, 8'h00); step();
        check_out("post_rst_lat1", 1'b0, 8'h00, 1'b0, 4'd0);
        drive(1'b0, MODE_ADD, 8'h00, 8'h00); step();
        check_out("post_rst_acc", 1'b1, 8'h07, 1'b0, 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
